// File: rtl/window_update_ctrl_pkg.sv
// rtl/window_update_ctrl_pkg.sv - shared state encoding for the window update controller
package window_update_ctrl_pkg;

   localparam int STATE_BITS = 2;

   typedef enum logic [STATE_BITS-1:0] {
      S_IDLE   = 2'd0,
      S_CLAMP  = 2'd1,
      S_PEND   = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

endpackage

// File: rtl/window_clamp.sv
// rtl/window_clamp.sv - combinational clamp of one window axis against the image size
module window_clamp #(
   parameter int C_BITS = 12
) (
   input  logic [C_BITS-1:0] pos,
   input  logic [C_BITS-1:0] len,
   input  logic [C_BITS-1:0] limit,
   output logic [C_BITS-1:0] pos_c,
   output logic [C_BITS-1:0] len_c,
   output logic              changed
);

   logic [C_BITS:0] sum;

   always_comb begin
      pos_c   = pos;
      len_c   = len;
      changed = 1'b0;
      sum     = '0;
      if (limit == '0) begin
         pos_c   = '0;
         len_c   = '0;
         changed = 1'b1;
      end else begin
         if (pos >= limit) pos_c = limit - 1'b1;
         if (len == '0) len_c = {{(C_BITS-1){1'b0}}, 1'b1};
         // Extra bit keeps the end-of-window sum from wrapping; width uses the clamped left
         sum = {1'b0, pos_c} + {1'b0, len_c};
         if (sum > {1'b0, limit}) len_c = limit - pos_c;
         changed = (pos_c != pos) || (len_c != len);
      end
   end

endmodule

// File: rtl/window_update_ctrl.sv
// rtl/window_update_ctrl.sv - accepts, clamps and frame-aligns window updates for the broadcaster
module window_update_ctrl
   import window_update_ctrl_pkg::*;
#(
   parameter int C_WBITS     = 12,
   parameter int C_HBITS     = 12,
   parameter int C_IMMEDIATE = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [C_WBITS-1:0] img_width,
   input  logic [C_HBITS-1:0] img_height,
   input  logic               sof,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [C_WBITS-1:0] req_left,
   input  logic [C_WBITS-1:0] req_width,
   input  logic [C_HBITS-1:0] req_top,
   input  logic [C_HBITS-1:0] req_height,
   output logic [C_WBITS-1:0] m_left,
   output logic [C_WBITS-1:0] m_width,
   output logic [C_HBITS-1:0] m_top,
   output logic [C_HBITS-1:0] m_height,
   output logic               pending,
   output logic               clamped,
   output logic               upd_done
);

   state_t state, state_next;

   logic [C_WBITS-1:0] cap_left, cap_width, pend_left, pend_width, h_pos, h_len;
   logic [C_HBITS-1:0] cap_top, cap_height, pend_top, pend_height, v_pos, v_len;
   logic               pend_changed, h_changed, v_changed, xfer;

   assign xfer = req_valid && req_ready;

   window_clamp #(.C_BITS(C_WBITS)) u_clamp_h (
      .pos(cap_left), .len(cap_width), .limit(img_width),
      .pos_c(h_pos), .len_c(h_len), .changed(h_changed)
   );

   window_clamp #(.C_BITS(C_HBITS)) u_clamp_v (
      .pos(cap_top), .len(cap_height), .limit(img_height),
      .pos_c(v_pos), .len_c(v_len), .changed(v_changed)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // A new request always beats sof in PEND: the newest window replaces the pending one
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (xfer) state_next = S_CLAMP;
         S_CLAMP:  state_next = ((C_IMMEDIATE != 0) || sof) ? S_COMMIT : S_PEND;
         S_PEND:   if (xfer) state_next = S_CLAMP;
                   else if (sof) state_next = S_COMMIT;
         S_COMMIT: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state == S_IDLE) || (state == S_PEND);
      pending   = (state == S_PEND);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_left     <= '0;
         cap_width    <= '0;
         cap_top      <= '0;
         cap_height   <= '0;
         pend_left    <= '0;
         pend_width   <= '0;
         pend_top     <= '0;
         pend_height  <= '0;
         pend_changed <= 1'b0;
         m_left       <= '0;
         m_width      <= '0;
         m_top        <= '0;
         m_height     <= '0;
         clamped      <= 1'b0;
         upd_done     <= 1'b0;
      end else begin
         if (xfer) begin
            cap_left   <= req_left;
            cap_width  <= req_width;
            cap_top    <= req_top;
            cap_height <= req_height;
         end
         if (state == S_CLAMP) begin
            pend_left    <= h_pos;
            pend_width   <= h_len;
            pend_top     <= v_pos;
            pend_height  <= v_len;
            pend_changed <= h_changed || v_changed;
         end
         if (state == S_COMMIT) begin
            m_left   <= pend_left;
            m_width  <= pend_width;
            m_top    <= pend_top;
            m_height <= pend_height;
            clamped  <= pend_changed;
         end
         upd_done <= (state == S_COMMIT);
      end
   end

endmodule

// File: tb/tb_window_update_ctrl.sv
// tb/tb_window_update_ctrl.sv - directed checks of immediate and sof-aligned window updates
module tb_window_update_ctrl;

   logic        clk = 1'b0;
   logic        reset, sof, req_valid;
   logic [11:0] img_width, img_height, req_left, req_width, req_top, req_height;

   logic        di_ready, di_pending, di_clamped, di_upd;
   logic [11:0] di_left, di_width, di_top, di_height;
   logic        dd_ready, dd_pending, dd_clamped, dd_upd;
   logic [11:0] dd_left, dd_width, dd_top, dd_height;

   int n_tests = 0;
   int n_fail  = 0;
   int upd_cnt = 0;

   always #5 clk = ~clk;

   window_update_ctrl #(.C_WBITS(12), .C_HBITS(12), .C_IMMEDIATE(1)) u_imm (
      .clk(clk), .reset(reset), .img_width(img_width), .img_height(img_height), .sof(sof),
      .req_valid(req_valid), .req_ready(di_ready), .req_left(req_left), .req_width(req_width),
      .req_top(req_top), .req_height(req_height), .m_left(di_left), .m_width(di_width),
      .m_top(di_top), .m_height(di_height), .pending(di_pending), .clamped(di_clamped),
      .upd_done(di_upd)
   );

   window_update_ctrl #(.C_WBITS(12), .C_HBITS(12), .C_IMMEDIATE(0)) u_sof (
      .clk(clk), .reset(reset), .img_width(img_width), .img_height(img_height), .sof(sof),
      .req_valid(req_valid), .req_ready(dd_ready), .req_left(req_left), .req_width(req_width),
      .req_top(req_top), .req_height(req_height), .m_left(dd_left), .m_width(dd_width),
      .m_top(dd_top), .m_height(dd_height), .pending(dd_pending), .clamped(dd_clamped),
      .upd_done(dd_upd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_cnt();
      tick();
      if (dd_upd) upd_cnt++;
   endtask

   task automatic put_req(input int l, input int w, input int t, input int h);
      req_valid  = 1'b1;
      req_left   = 12'(l);
      req_width  = 12'(w);
      req_top    = 12'(t);
      req_height = 12'(h);
   endtask

   initial begin
      reset = 1'b1; sof = 1'b0; req_valid = 1'b0;
      img_width = 12'd1920; img_height = 12'd1080;
      req_left = '0; req_width = '0; req_top = '0; req_height = '0;
      tick(); tick();
      reset = 1'b0;
      tick();
      check("rst_m_left", dd_left, 0);
      check("rst_pending", dd_pending, 0);
      check("rst_ready_sof", dd_ready, 1);
      check("rst_ready_imm", di_ready, 1);
      check("rst_upd", di_upd, 0);

      // immediate mode: transfer at N, visible at N+3
      put_req(100, 200, 50, 60);
      tick(); req_valid = 1'b0;
      check("t1_busy", di_ready, 0);
      tick();
      check("t1_pre_left", di_left, 0);
      check("t2_pending", dd_pending, 1);
      tick();
      check("t1_left", di_left, 100);
      check("t1_width", di_width, 200);
      check("t1_top", di_top, 50);
      check("t1_height", di_height, 60);
      check("t1_upd", di_upd, 1);
      check("t1_clamped", di_clamped, 0);
      tick();
      check("t1_upd_pulse", di_upd, 0);

      // sof mode: held pending until the frame boundary
      repeat (9) tick();
      check("t2_hold_pend", dd_pending, 1);
      check("t2_hold_left", dd_left, 0);
      check("t2_hold_upd", dd_upd, 0);
      sof = 1'b1;
      tick(); sof = 1'b0;
      check("t2_commit_pend", dd_pending, 0);
      check("t2_commit_left", dd_left, 0);
      tick();
      check("t2_left", dd_left, 100);
      check("t2_height", dd_height, 60);
      check("t2_upd", dd_upd, 1);
      check("t2_clamped", dd_clamped, 0);
      tick();

      // clamping at both far edges
      put_req(1900, 100, 1080, 0);
      tick(); req_valid = 1'b0;
      tick(); tick();
      check("t3_left", di_left, 1900);
      check("t3_width", di_width, 20);
      check("t3_top", di_top, 1079);
      check("t3_height", di_height, 1);
      check("t3_clamped", di_clamped, 1);
      check("t3_sof_pend", dd_pending, 1);

      // new request together with sof replaces the pending window
      upd_cnt = 0;
      put_req(10, 20, 30, 40);
      sof = 1'b1;
      tick_cnt(); req_valid = 1'b0; sof = 1'b0;
      tick_cnt();
      check("t4_pend", dd_pending, 1);
      check("t4_keep_left", dd_left, 100);
      repeat (3) tick_cnt();
      sof = 1'b1;
      tick_cnt(); sof = 1'b0;
      tick_cnt();
      check("t4_left", dd_left, 10);
      check("t4_width", dd_width, 20);
      check("t4_top", dd_top, 30);
      check("t4_height", dd_height, 40);
      check("t4_clamped", dd_clamped, 0);
      repeat (3) tick_cnt();
      check("t4_upd_count", upd_cnt, 1);

      // sof during CLAMP commits at once; zero image width collapses the axis
      img_width = 12'd0;
      put_req(5, 7, 3, 4);
      tick(); req_valid = 1'b0; sof = 1'b1;
      tick(); sof = 1'b0;
      tick();
      check("t5_left", dd_left, 0);
      check("t5_width", dd_width, 0);
      check("t5_top", dd_top, 3);
      check("t5_height", dd_height, 4);
      check("t5_clamped", dd_clamped, 1);
      check("t5_upd", dd_upd, 1);
      check("t5_imm_width", di_width, 0);
      check("t5_imm_clamped", di_clamped, 1);

      // reset while pending drops the window
      img_width = 12'd1920;
      tick();
      put_req(1, 2, 3, 4);
      tick(); req_valid = 1'b0;
      tick(); tick();
      check("t6_pend", dd_pending, 1);
      reset = 1'b1;
      tick(); reset = 1'b0;
      check("t6_pending", dd_pending, 0);
      check("t6_left", dd_left, 0);
      check("t6_width", dd_width, 0);
      check("t6_top", dd_top, 0);
      check("t6_clamped", dd_clamped, 0);
      check("t6_ready", dd_ready, 1);
      upd_cnt = 0;
      sof = 1'b1;
      tick_cnt(); sof = 1'b0;
      repeat (3) tick_cnt();
      check("t6_no_upd", upd_cnt, 0);
      check("t6_height", dd_height, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
